// File: rtl/score_overlay.sv
// score_overlay: composites a two-digit score for each side on top of the
// game layer. Scores are latched once per frame and a side that changes
// blinks for BLINK_FRAMES frames. Two-stage pipeline: stage 1 works out which
// cell and glyph position the pixel falls in, stage 2 does the font lookup
// and the final colour mux. Sync and blank travel alongside the pixel.
module score_overlay #(
   parameter int unsigned BLINK_FRAMES = 120
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        HS_in,
   input  logic        VS_in,
   input  logic        blank_in,
   input  logic [8:0]  row,
   input  logic [9:0]  col,
   input  logic [23:0] rgb_in,
   input  logic        frame_end,
   input  logic [7:0]  left_bcd,
   input  logic [7:0]  right_bcd,
   output logic        HS,
   output logic        VS,
   output logic        blank,
   output logic [23:0] rgb
);

   localparam logic [7:0]  BLINK_LOAD = 8'(BLINK_FRAMES);
   localparam logic [23:0] WHITE      = 24'hFFFFFF;

   // Scores and blink counters as seen by the current frame.
   logic [7:0] shown_left;
   logic [7:0] shown_right;
   logic [7:0] blink_left;
   logic [7:0] blink_right;
   logic       left_hidden;
   logic       right_hidden;

   // Stage 1 combinational results.
   logic       in_band;
   logic       cell_hit;
   logic       side_hidden;
   logic [3:0] digit_sel;
   logic [2:0] glyph_row_s0;
   logic [2:0] glyph_col_s0;
   logic       visible_s0;

   // Stage 1 registers.
   logic        hs_s1;
   logic        vs_s1;
   logic        blank_s1;
   logic [23:0] rgb_s1;
   logic        visible_s1;
   logic [3:0]  digit_s1;
   logic [2:0]  glyph_row_s1;
   logic [2:0]  glyph_col_s1;

   // Stage 2 combinational results.
   logic [63:0] glyph_word;
   logic [7:0]  glyph_bits;
   logic        pixel_on;

   // 8x8 digit font; row 0 is the most significant byte, bit 7 the leftmost pixel.
   function automatic logic [63:0] font_glyph(input logic [3:0] digit);
      case (digit)
         4'd0:    font_glyph = 64'h3C666E7666663C00;
         4'd1:    font_glyph = 64'h183818181818_7E00;
         4'd2:    font_glyph = 64'h3C66060C30607E00;
         4'd3:    font_glyph = 64'h3C66061C06663C00;
         4'd4:    font_glyph = 64'h0C1C3C6C7E0C0C00;
         4'd5:    font_glyph = 64'h7E607C0606663C00;
         4'd6:    font_glyph = 64'h3C66607C66663C00;
         4'd7:    font_glyph = 64'h7E060C1830303000;
         4'd8:    font_glyph = 64'h3C66663C66663C00;
         4'd9:    font_glyph = 64'h3C66663E06663C00;
         default: font_glyph = 64'h0;
      endcase
   endfunction

   // A side is hidden during the "off" half of each 16-frame blink period.
   assign left_hidden  = (blink_left  != 8'd0) && blink_left[3];
   assign right_hidden = (blink_right != 8'd0) && blink_right[3];

   // Latch scores at frame end so a frame never shows a mix of old and new digits; a change restarts that side's blink.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         shown_left  <= 8'h00;
         shown_right <= 8'h00;
         blink_left  <= 8'd0;
         blink_right <= 8'd0;
      end else if (frame_end) begin
         shown_left  <= left_bcd;
         shown_right <= right_bcd;
         if (left_bcd != shown_left)
            blink_left <= BLINK_LOAD;
         else if (blink_left != 8'd0)
            blink_left <= blink_left - 8'd1;
         if (right_bcd != shown_right)
            blink_right <= BLINK_LOAD;
         else if (blink_right != 8'd0)
            blink_right <= blink_right - 8'd1;
      end
   end

   // Stage 1: find the digit cell under the pixel and its position inside the scaled glyph.
   always_comb begin
      in_band     = (row >= 9'd16) && (row <= 9'd47);
      cell_hit    = 1'b0;
      side_hidden = 1'b0;
      digit_sel   = 4'd0;
      // Cell bases are multiples of 32, so the in-cell column offset is just col[4:0];
      // the band starts at row 16, so subtracting 16 then dividing by 4 is adding 4 mod 8.
      glyph_col_s0 = col[4:2];
      glyph_row_s0 = row[4:2] + 3'd4;
      if (in_band) begin
         if ((col >= 10'd256) && (col <= 10'd287)) begin
            cell_hit    = 1'b1;
            digit_sel   = shown_left[7:4];
            side_hidden = left_hidden;
         end else if ((col >= 10'd288) && (col <= 10'd319)) begin
            cell_hit    = 1'b1;
            digit_sel   = shown_left[3:0];
            side_hidden = left_hidden;
         end else if ((col >= 10'd352) && (col <= 10'd383)) begin
            cell_hit    = 1'b1;
            digit_sel   = shown_right[7:4];
            side_hidden = right_hidden;
         end else if ((col >= 10'd384) && (col <= 10'd415)) begin
            cell_hit    = 1'b1;
            digit_sel   = shown_right[3:0];
            side_hidden = right_hidden;
         end
      end
      // Nibbles above 9 are not digits and leave the whole cell transparent.
      visible_s0 = cell_hit && (digit_sel <= 4'd9) && !side_hidden;
   end

   // Stage 1 register: carry timing signals and the cell decode forward one clock.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         hs_s1        <= 1'b1;
         vs_s1        <= 1'b1;
         blank_s1     <= 1'b1;
         rgb_s1       <= 24'h000000;
         visible_s1   <= 1'b0;
         digit_s1     <= 4'd0;
         glyph_row_s1 <= 3'd0;
         glyph_col_s1 <= 3'd0;
      end else begin
         hs_s1        <= HS_in;
         vs_s1        <= VS_in;
         blank_s1     <= blank_in;
         rgb_s1       <= rgb_in;
         visible_s1   <= visible_s0;
         digit_s1     <= digit_sel;
         glyph_row_s1 <= glyph_row_s0;
         glyph_col_s1 <= glyph_col_s0;
      end
   end

   // Stage 2: pick the glyph row from the font and the pixel bit within it.
   always_comb begin
      glyph_word = font_glyph(digit_s1);
      glyph_bits = glyph_word[{~glyph_row_s1, 3'b000} +: 8];
      pixel_on   = glyph_bits[~glyph_col_s1];
   end

   // Stage 2 register: final colour mux; blanking is left to the downstream DAC stage.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         HS    <= 1'b1;
         VS    <= 1'b1;
         blank <= 1'b1;
         rgb   <= 24'h000000;
      end else begin
         HS    <= hs_s1;
         VS    <= vs_s1;
         blank <= blank_s1;
         rgb   <= (visible_s1 && pixel_on) ? WHITE : rgb_s1;
      end
   end

endmodule

// File: tb/tb_score_overlay.sv
// tb_score_overlay: directed self-checking bench for score_overlay.
// Pixel checks come from a hand-computed vector table plus sequences for
// frame latching, blinking, invalid BCD and asynchronous reset.
module tb_score_overlay;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n;
   logic        HS_in;
   logic        VS_in;
   logic        blank_in;
   logic [8:0]  row;
   logic [9:0]  col;
   logic [23:0] rgb_in;
   logic        frame_end;
   logic [7:0]  left_bcd;
   logic [7:0]  right_bcd;
   logic        HS;
   logic        VS;
   logic        blank;
   logic [23:0] rgb;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [8:0] r;
      logic [9:0] c;
      logic       white;
   } pix_vec_t;

   pix_vec_t    vecs [18];
   logic [26:0] hist [20];
   int          cnt_model;
   logic [7:0]  shown_model;
   logic [7:0]  next_val;
   logic        exp_hidden;

   score_overlay #(.BLINK_FRAMES(120)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .HS_in    (HS_in),
      .VS_in    (VS_in),
      .blank_in (blank_in),
      .row      (row),
      .col      (col),
      .rgb_in   (rgb_in),
      .frame_end(frame_end),
      .left_bcd (left_bcd),
      .right_bcd(right_bcd),
      .HS       (HS),
      .VS       (VS),
      .blank    (blank),
      .rgb      (rgb)
   );

   // 50 MHz clock.
   always #10 CLOCK_50 = ~CLOCK_50;

   // Guard against the bench ever hanging.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Present one pixel and wait for it to reach the outputs; returns on a negedge.
   task automatic applyStimulus(input logic [8:0] r, input logic [9:0] c, input logic [23:0] pix_in);
      row       = r;
      col       = c;
      rgb_in    = pix_in;
      HS_in     = 1'b1;
      VS_in     = 1'b1;
      blank_in  = 1'b0;
      frame_end = 1'b0;
      @(posedge CLOCK_50);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic check_pixel(input string name, input logic [8:0] r, input logic [9:0] c, input logic white);
      logic [23:0] pix_in;
      pix_in = {8'h40 ^ r[7:0], 6'd0, c};
      applyStimulus(r, c, pix_in);
      checkOutput(name, {8'h00, rgb}, {8'h00, white ? 24'hFFFFFF : pix_in});
   endtask

   // Hold frame_end for n rising edges; starts and ends on a negedge.
   task automatic pulse_frames(input int n);
      frame_end = 1'b1;
      repeat (n) @(negedge CLOCK_50);
      frame_end = 1'b0;
   endtask

   initial begin
      // Expected pixels with left=10, right=00, no blinking.
      vecs[0]  = '{r: 9'd16, c: 10'd256, white: 1'b0};
      vecs[1]  = '{r: 9'd16, c: 10'd268, white: 1'b1};
      vecs[2]  = '{r: 9'd16, c: 10'd264, white: 1'b0};
      vecs[3]  = '{r: 9'd16, c: 10'd272, white: 1'b1};
      vecs[4]  = '{r: 9'd20, c: 10'd264, white: 1'b1};
      vecs[5]  = '{r: 9'd40, c: 10'd260, white: 1'b1};
      vecs[6]  = '{r: 9'd44, c: 10'd268, white: 1'b0};
      vecs[7]  = '{r: 9'd16, c: 10'd296, white: 1'b1};
      vecs[8]  = '{r: 9'd15, c: 10'd268, white: 1'b0};
      vecs[9]  = '{r: 9'd48, c: 10'd268, white: 1'b0};
      vecs[10] = '{r: 9'd16, c: 10'd360, white: 1'b1};
      vecs[11] = '{r: 9'd28, c: 10'd388, white: 1'b1};
      vecs[12] = '{r: 9'd28, c: 10'd384, white: 1'b0};
      vecs[13] = '{r: 9'd16, c: 10'd336, white: 1'b0};
      vecs[14] = '{r: 9'd16, c: 10'd416, white: 1'b0};
      vecs[15] = '{r: 9'd28, c: 10'd312, white: 1'b1};
      vecs[16] = '{r: 9'd47, c: 10'd300, white: 1'b0};
      vecs[17] = '{r: 9'd43, c: 10'd296, white: 1'b1};

      reset_n   = 1'b0;
      HS_in     = 1'b0;
      VS_in     = 1'b0;
      blank_in  = 1'b0;
      rgb_in    = 24'h123456;
      row       = 9'd0;
      col       = 10'd0;
      frame_end = 1'b0;
      left_bcd  = 8'h00;
      right_bcd = 8'h00;

      // Reset values while reset is held.
      repeat (3) @(negedge CLOCK_50);
      checkOutput("reset_HS", {31'd0, HS}, 32'd1);
      checkOutput("reset_VS", {31'd0, VS}, 32'd1);
      checkOutput("reset_blank", {31'd0, blank}, 32'd1);
      checkOutput("reset_rgb", {8'h00, rgb}, 32'h0);
      reset_n = 1'b1;

      // Random timing and colour outside the cells must appear exactly two clocks later.
      row = 9'd200;
      col = 10'd100;
      for (int k = 0; k < 20; k++) begin
         if (k >= 2)
            checkOutput($sformatf("latency%0d", k), {5'd0, HS, VS, blank, rgb}, {5'd0, hist[k-2]});
         hist[k] = {1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom)};
         {HS_in, VS_in, blank_in, rgb_in} = hist[k];
         @(negedge CLOCK_50);
      end

      // Latch left=10 and let its blink run out.
      left_bcd  = 8'h10;
      right_bcd = 8'h00;
      pulse_frames(1);
      check_pixel("blink_load_hidden", 9'd16, 10'd268, 1'b0);
      pulse_frames(120);

      for (int i = 0; i < 18; i++)
         check_pixel($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].white);

      // Mid-frame score change must not show until frame end.
      right_bcd = 8'h07;
      check_pixel("midframe_ones", 9'd16, 10'd388, 1'b0);
      check_pixel("midframe_tens", 9'd16, 10'd360, 1'b1);
      pulse_frames(1);
      check_pixel("latched_hidden_ones", 9'd16, 10'd388, 1'b0);
      check_pixel("latched_hidden_tens", 9'd16, 10'd360, 1'b0);
      check_pixel("left_unaffected", 9'd16, 10'd268, 1'b1);
      pulse_frames(1);
      check_pixel("seven_shown", 9'd16, 10'd388, 1'b1);
      check_pixel("tens_shown", 9'd16, 10'd360, 1'b1);
      pulse_frames(119);

      // Bring left back to 00 and settle before the blink sequence.
      left_bcd = 8'h00;
      pulse_frames(121);

      // Blink sequence: 00->01, then 01->02 fifty frames later.
      shown_model = 8'h00;
      cnt_model   = 0;
      for (int f = 1; f <= 175; f++) begin
         next_val = (f < 51) ? 8'h01 : 8'h02;
         left_bcd = next_val;
         pulse_frames(1);
         if (next_val != shown_model)
            cnt_model = 120;
         else if (cnt_model > 0)
            cnt_model--;
         shown_model = next_val;
         exp_hidden  = (cnt_model != 0) && cnt_model[3];
         check_pixel($sformatf("blink_f%0d", f), 9'd16, 10'd264, !exp_hidden);
      end

      // Invalid ones nibble with simultaneous change on both sides.
      left_bcd  = 8'h1A;
      right_bcd = 8'h00;
      pulse_frames(1);
      check_pixel("both_hidden_left", 9'd16, 10'd268, 1'b0);
      check_pixel("both_hidden_right", 9'd16, 10'd360, 1'b0);
      pulse_frames(1);
      check_pixel("invalid_tens", 9'd16, 10'd268, 1'b1);
      check_pixel("invalid_ones_a", 9'd16, 10'd296, 1'b0);
      check_pixel("invalid_ones_b", 9'd40, 10'd300, 1'b0);
      check_pixel("right_back", 9'd16, 10'd360, 1'b1);
      check_pixel("pre_reset_ones", 9'd16, 10'd296, 1'b0);

      // Asynchronous reset in the middle of a line.
      row      = 9'd200;
      col      = 10'd100;
      HS_in    = 1'b0;
      VS_in    = 1'b0;
      blank_in = 1'b0;
      rgb_in   = 24'hABCDEF;
      @(posedge CLOCK_50);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      checkOutput("pre_reset_outputs", {5'd0, HS, VS, blank, rgb}, {5'd0, 3'b000, 24'hABCDEF});
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("async_HS", {31'd0, HS}, 32'd1);
      checkOutput("async_VS", {31'd0, VS}, 32'd1);
      checkOutput("async_blank", {31'd0, blank}, 32'd1);
      checkOutput("async_rgb", {8'h00, rgb}, 32'h0);
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      check_pixel("post_reset_tens", 9'd16, 10'd264, 1'b1);
      check_pixel("post_reset_ones", 9'd16, 10'd296, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
